// File: rtl/altitude_pkg.sv
// Shared constants for the velocity -> altitude -> gimbal chain.
// Unit scales: velocity in 1e-9 m/s, accumulator in 1e-15 m, altitude in mm.
package altitude_pkg;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_DIV  = 2'd1;
   localparam state_t ST_OUT  = 2'd2;

   localparam int          ACC_W     = 96;
   localparam logic [63:0] DIV_CONST = 64'd1_000_000_000_000;
   localparam int          MM_PER_KM = 1000;

   // Decimal exponents of the fixed-point units (value = raw * 10^-EXP).
   localparam int VEL_SCALE_EXP = 9;
   localparam int ACC_SCALE_EXP = 15;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider by a constant: one quotient bit per cycle, DVD_W iterations after load.
// done is high for one cycle once the quotient is final; abort drops the operation.
module seq_divider #(
   parameter int          DVD_W   = 96,
   parameter int          DVS_W   = 64,
   parameter logic [63:0] DIVISOR = 64'd1_000_000_000_000
) (
   input  logic             clk,
   input  logic             resetb,
   input  logic             start,
   input  logic             abort,
   input  logic [DVD_W-1:0] dividend,
   output logic             busy,
   output logic             done,
   output logic [DVD_W-1:0] quotient
);

   localparam int CNT_W = $clog2(DVD_W + 1);

   logic [DVS_W:0]   rem;
   logic [DVS_W:0]   trial;
   logic [CNT_W-1:0] cnt;
   logic             fits;

   // quotient doubles as the dividend shift register: dividend bits leave at
   // the top while quotient bits enter at the bottom.
   assign trial = {rem[DVS_W-1:0], quotient[DVD_W-1]};
   assign fits  = (trial >= {1'b0, DIVISOR[DVS_W-1:0]});
   assign done  = busy && (cnt == '0);

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         busy     <= 1'b0;
         cnt      <= '0;
         rem      <= '0;
         quotient <= '0;
      end else if (abort) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (start) begin
         busy     <= 1'b1;
         cnt      <= CNT_W'(DVD_W);
         rem      <= '0;
         quotient <= dividend;
      end else if (busy && cnt != '0) begin
         rem      <= fits ? (trial - {1'b0, DIVISOR[DVS_W-1:0]}) : trial;
         quotient <= {quotient[DVD_W-2:0], fits};
         cnt      <= cnt - 1'b1;
      end else if (busy) begin
         busy <= 1'b0;
      end
   end

endmodule

// File: rtl/altitude_integrator.sv
// Integrates velocity samples into altitude (mm) and flags the target altitude.
// One sample per ACC_W+4 cycles; vel_ready drops while a division is in flight.
module altitude_integrator #(
   parameter int          DT_US     = 20,
   parameter logic [63:0] TARGET_MM = 64'd30_000_000,
   parameter int          ACC_W     = altitude_pkg::ACC_W,
   parameter logic [63:0] DIV_CONST = altitude_pkg::DIV_CONST
) (
   input  logic        clk,
   input  logic        resetb,
   input  logic        clear,
   input  logic [63:0] velocity,
   input  logic        vel_valid,
   output logic        vel_ready,
   output logic [63:0] altitude_mm,
   output logic        alt_valid,
   output logic        reached,
   output logic        saturated
);
   import altitude_pkg::*;

   localparam logic [7:0] DT8 = DT_US[7:0];

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [71:0]      prod;
   logic [ACC_W:0]   sum;
   logic             start_q;
   logic             div_start;
   logic             div_busy;
   logic             div_done;
   logic [ACC_W-1:0] div_q;
   logic [63:0]      q_clip;

   assign prod      = 72'(velocity) * 72'(DT8);
   assign sum       = {1'b0, acc} + (ACC_W+1)'(prod);
   assign div_start = start_q && !div_busy;
   assign q_clip    = (|div_q[ACC_W-1:64]) ? {64{1'b1}} : div_q[63:0];

   seq_divider #(
      .DVD_W   (ACC_W),
      .DVS_W   (64),
      .DIVISOR (DIV_CONST)
   ) u_div (
      .clk      (clk),
      .resetb   (resetb),
      .start    (div_start),
      .abort    (clear),
      .dividend (acc),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_q)
   );

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state       <= ST_IDLE;
         acc         <= '0;
         start_q     <= 1'b0;
         vel_ready   <= 1'b1;
         altitude_mm <= '0;
         alt_valid   <= 1'b0;
         reached     <= 1'b0;
         saturated   <= 1'b0;
      end else if (clear) begin
         // Any sample offered this cycle is dropped along with the in-flight divide.
         state       <= ST_IDLE;
         acc         <= '0;
         start_q     <= 1'b0;
         vel_ready   <= 1'b1;
         altitude_mm <= '0;
         alt_valid   <= 1'b0;
         reached     <= 1'b0;
         saturated   <= 1'b0;
      end else begin
         start_q   <= 1'b0;
         alt_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (vel_valid && vel_ready) begin
                  if (sum[ACC_W]) begin
                     acc       <= {ACC_W{1'b1}};
                     saturated <= 1'b1;
                  end else begin
                     acc <= sum[ACC_W-1:0];
                  end
                  start_q   <= 1'b1;
                  vel_ready <= 1'b0;
                  state     <= ST_DIV;
               end
            end
            ST_DIV: begin
               if (div_done) begin
                  altitude_mm <= q_clip;
                  alt_valid   <= 1'b1;
                  reached     <= reached | (q_clip >= TARGET_MM);
                  state       <= ST_OUT;
               end
            end
            ST_OUT: begin
               vel_ready <= 1'b1;
               state     <= ST_IDLE;
            end
            default: begin
               vel_ready <= 1'b1;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_altitude_integrator.sv
// Directed bench: unit A (target 100 mm) for function/flags, unit B (72-bit acc) for saturation.
module tb_altitude_integrator;

   localparam logic [63:0] V1000 = 64'd1_000_000_000_000;
   localparam logic [63:0] VMAX  = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        resetb, clear;
   logic [63:0] velocity_a, velocity_b;
   logic        vel_valid_a, vel_valid_b;
   logic        vel_ready_a, vel_ready_b;
   logic [63:0] altitude_mm_a, altitude_mm_b;
   logic        alt_valid_a, alt_valid_b;
   logic        reached_a, reached_b;
   logic        saturated_a, saturated_b;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   altitude_integrator #(.TARGET_MM(64'd100)) dut_a (
      .clk(clk), .resetb(resetb), .clear(clear),
      .velocity(velocity_a), .vel_valid(vel_valid_a), .vel_ready(vel_ready_a),
      .altitude_mm(altitude_mm_a), .alt_valid(alt_valid_a),
      .reached(reached_a), .saturated(saturated_a)
   );

   altitude_integrator #(.ACC_W(72)) dut_b (
      .clk(clk), .resetb(resetb), .clear(clear),
      .velocity(velocity_b), .vel_valid(vel_valid_b), .vel_ready(vel_ready_b),
      .altitude_mm(altitude_mm_b), .alt_valid(alt_valid_b),
      .reached(reached_b), .saturated(saturated_b)
   );

   typedef struct {
      bit          clr;
      logic [63:0] vel;
      logic [63:0] alt;
      bit          rch;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   // Present one sample and return at the first negedge after the accept edge.
   task automatic accept(input bit b, input logic [63:0] v, input bit hold);
      int n = 0;
      while (!(b ? vel_ready_b : vel_ready_a) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (b) begin velocity_b = v; vel_valid_b = 1'b1; end
      else   begin velocity_a = v; vel_valid_a = 1'b1; end
      @(posedge clk);
      @(negedge clk);
      if (!hold) begin vel_valid_a = 1'b0; vel_valid_b = 1'b0; end
   endtask

   // lat counts cycles from the accept cycle (cycle 0); -1 when alt_valid never arrives.
   task automatic wait_alt(input bit b, output int lat);
      lat = 1;
      while (!(b ? alt_valid_b : alt_valid_a) && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      vel_valid_a = 1'b0;
      vel_valid_b = 1'b0;
      if (lat >= 300) lat = -1;
   endtask

   task automatic send(input bit b, input logic [63:0] v, input bit hold, output int lat);
      accept(b, v, hold);
      wait_alt(b, lat);
   endtask

   task automatic count_alt(input int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (alt_valid_a) cnt++;
      end
   endtask

   initial begin
      int           lat;
      int           cnt;
      logic [63:0]  prev;

      tbl[0] = '{1'b0, V1000, 64'd20,  1'b0};
      tbl[1] = '{1'b0, V1000, 64'd40,  1'b0};
      tbl[2] = '{1'b0, V1000, 64'd60,  1'b0};
      tbl[3] = '{1'b0, V1000, 64'd80,  1'b0};
      tbl[4] = '{1'b0, V1000, 64'd100, 1'b1};
      tbl[5] = '{1'b0, V1000, 64'd120, 1'b1};
      tbl[6] = '{1'b1, 64'd49_999_999_999, 64'd0, 1'b0};
      tbl[7] = '{1'b0, 64'd49_999_999_999, 64'd1, 1'b0};

      resetb = 1'b0; clear = 1'b0;
      velocity_a = '0; velocity_b = '0; vel_valid_a = 1'b0; vel_valid_b = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_alt",   altitude_mm_a, 64'd0);
      check("rst_valid", 64'(alt_valid_a), 64'd0);
      check("rst_reach", 64'(reached_a), 64'd0);
      check("rst_sat",   64'(saturated_a), 64'd0);
      check("rst_ready", 64'(vel_ready_a), 64'd1);
      resetb = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         if (tbl[i].clr) pulse_clear();
         send(1'b0, tbl[i].vel, 1'b0, lat);
         check($sformatf("vec%0d_lat", i),   64'(lat), 64'd99);
         check($sformatf("vec%0d_alt", i),   altitude_mm_a, tbl[i].alt);
         check($sformatf("vec%0d_reach", i), 64'(reached_a), 64'(tbl[i].rch));
         check($sformatf("vec%0d_sat", i),   64'(saturated_a), 64'd0);
      end

      // Held vel_valid during DIV must accumulate exactly once.
      pulse_clear();
      send(1'b0, V1000, 1'b1, lat);
      check("hold_lat", 64'(lat), 64'd99);
      check("hold_alt", altitude_mm_a, 64'd20);
      check("hold_rdy_in_out", 64'(vel_ready_a), 64'd0);
      @(negedge clk);
      check("hold_rdy_back", 64'(vel_ready_a), 64'd1);
      check("hold_pulse_len", 64'(alt_valid_a), 64'd0);
      send(1'b0, V1000, 1'b0, lat);
      check("hold_next_alt", altitude_mm_a, 64'd40);

      // Clear mid-divide aborts without a result.
      accept(1'b0, V1000, 1'b0);
      repeat (30) @(negedge clk);
      pulse_clear();
      count_alt(150, cnt);
      check("clrdiv_no_valid", 64'(cnt), 64'd0);
      check("clrdiv_alt",      altitude_mm_a, 64'd0);
      check("clrdiv_ready",    64'(vel_ready_a), 64'd1);
      send(1'b0, V1000, 1'b0, lat);
      check("clrdiv_restart", altitude_mm_a, 64'd20);

      // Clear beats a simultaneous accept.
      velocity_a = V1000; vel_valid_a = 1'b1; clear = 1'b1;
      @(negedge clk);
      vel_valid_a = 1'b0; clear = 1'b0;
      check("clracc_ready", 64'(vel_ready_a), 64'd1);
      count_alt(120, cnt);
      check("clracc_no_valid", 64'(cnt), 64'd0);
      send(1'b0, V1000, 1'b0, lat);
      check("clracc_alt", altitude_mm_a, 64'd20);

      // Reset during a divide, with reached already set.
      for (int i = 0; i < 4; i++) send(1'b0, V1000, 1'b0, lat);
      check("pre_rst_reach", 64'(reached_a), 64'd1);
      accept(1'b0, V1000, 1'b0);
      repeat (40) @(negedge clk);
      resetb = 1'b0;
      #1;
      check("midrst_alt",   altitude_mm_a, 64'd0);
      check("midrst_reach", 64'(reached_a), 64'd0);
      check("midrst_ready", 64'(vel_ready_a), 64'd1);
      check("midrst_valid", 64'(alt_valid_a), 64'd0);
      @(negedge clk);
      resetb = 1'b1;
      count_alt(150, cnt);
      check("midrst_no_valid", 64'(cnt), 64'd0);
      send(1'b0, V1000, 1'b0, lat);
      check("midrst_restart", altitude_mm_a, 64'd20);

      // Saturation on the 72-bit unit: 13th max-velocity sample overflows.
      prev = '0;
      for (int i = 0; i < 14; i++) begin
         send(1'b1, VMAX, 1'b0, lat);
         check($sformatf("sat%0d_lat", i), 64'(lat), 64'd75);
         check($sformatf("sat%0d_mono", i), 64'(altitude_mm_b >= prev), 64'd1);
         prev = altitude_mm_b;
         if (i == 0) begin
            check("sat_first_alt",   altitude_mm_b, 64'd368934881);
            check("sat_first_reach", 64'(reached_b), 64'd1);
         end
         if (i == 11) begin
            check("sat12_alt", altitude_mm_b, 64'd4427218577);
            check("sat12_flag", 64'(saturated_b), 64'd0);
         end
         if (i >= 12) begin
            check($sformatf("sat%0d_alt", i), altitude_mm_b, 64'd4722366482);
            check($sformatf("sat%0d_flag", i), 64'(saturated_b), 64'd1);
         end
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
